// File: rtl/dual_port_dram.sv
// -----------------------------------------------------------------------------
// dual_port_dram
//
// Simple dual-port RAM used as the storage array of the TLP-path FIFOs.
// Port A is write-only, port B is read-only, both on one clock. Read data is
// registered (one cycle latency) and holds while re_b is low. The whole array
// and q_b clear asynchronously while reset_L is low.
//
// Same-address collision (we_a & re_b & addr_a == addr_b):
//   default               : read-first, q_b gets the old word.
//   DRAM_WR_BYPASS_EN set  : write-first, data_a is forwarded to q_b.
// The array is written in both builds.
//
// Ports:
//   clk      in   1           single clock, rising edge
//   reset_L  in   1           asynchronous active-low reset
//   data_a   in   DATA_WIDTH  port A write data
//   addr_a   in   ADDR_WIDTH  port A write address
//   we_a     in   1           port A write enable, active-high
//   addr_b   in   ADDR_WIDTH  port B read address
//   re_b     in   1           port B read enable, active-high
//   q_b      out  DATA_WIDTH  port B registered read data
//
// Parameters: DATA_WIDTH (4), ADDR_WIDTH (3), DEPTH (8, must be 2**ADDR_WIDTH).
// Optional macro: DRAM_WR_BYPASS_EN
// -----------------------------------------------------------------------------
module dual_port_dram #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  re_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] q_b_q;
    logic [DATA_WIDTH-1:0] q_b_d;

    // Next-state for the array and the read register.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, otherwise a latch is inferred.
        mem_d = mem_q;
        q_b_d = q_b_q;

        if (we_a) begin
            mem_d[addr_a] = data_a;
        end

        if (re_b) begin
`ifdef DRAM_WR_BYPASS_EN
            // Write-first: a same-address write is forwarded straight to q_b.
            if (we_a && (addr_a == addr_b)) begin
                q_b_d = data_a;
            end else begin
                q_b_d = mem_q[addr_b];
            end
`else
            // Read-first: reading mem_q (not mem_d) returns the pre-write word.
            q_b_d = mem_q[addr_b];
`endif
        end
    end

    // NOTE: the array is built from flops rather than a RAM macro because it
    // must clear asynchronously; a block RAM cannot be reset this way.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            q_b_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together from the values sampled at the edge.
            mem_q <= mem_d;
            q_b_q <= q_b_d;
        end
    end

    assign q_b = q_b_q;

endmodule

// File: tb/tb_dual_port_dram.sv
// -----------------------------------------------------------------------------
// tb_dual_port_dram
//
// Directed bench for dual_port_dram. Inputs change 1 time unit after each
// rising edge; outputs are checked 1 time unit after the edge that should
// have produced them. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dual_port_dram;

    localparam int DW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [DW-1:0] data_a;
    logic [AW-1:0] addr_a;
    logic          we_a;
    logic [AW-1:0] addr_b;
    logic          re_b;
    logic [DW-1:0] q_b;

    int checks = 0;
    int errors = 0;

    dual_port_dram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (8)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .data_a  (data_a),
        .addr_a  (addr_a),
        .we_a    (we_a),
        .addr_b  (addr_b),
        .re_b    (re_b),
        .q_b     (q_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re,
                         input logic [AW-1:0] ra);
        we_a   = we;
        addr_a = wa;
        data_a = wd;
        re_b   = re;
        addr_b = ra;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] exp_v;

        // Reset before any clock edge: asynchronous clear.
        drive(1'b0, '0, '0, 1'b0, '0);
        reset_L = 1'b1;
        #2 reset_L = 1'b0;
        #1 check("reset_before_clk", q_b, 4'b0000);

        // Edges while in reset: write and read ignored.
        drive(1'b1, 3'd1, 4'b0110, 1'b1, 3'd1);
        tick();
        check("reset_ignores_ops", q_b, 4'b0000);
        drive(1'b0, '0, '0, 1'b0, '0);
        #2 reset_L = 1'b1;

        // Cleared word reads zero, also proves the write during reset was lost.
        tick();
        drive(1'b0, '0, '0, 1'b1, 3'd1);
        tick();
        check("read_after_reset_addr1", q_b, 4'b0000);

        // Basic write then read of addr 0.
        drive(1'b1, 3'd0, 4'b0001, 1'b0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd0);
        tick();
        check("basic_read_addr0", q_b, 4'b0001);

        // Read hold: re_b low, address changes, q_b unchanged.
        drive(1'b0, 3'd0, 4'b0000, 1'b0, 3'd3);
        tick();
        check("hold_1", q_b, 4'b0001);
        tick();
        check("hold_2", q_b, 4'b0001);

        // we_a low with data present must not write.
        drive(1'b0, 3'd0, 4'b1111, 1'b0, 3'd3);
        tick();
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd0);
        tick();
        check("no_write_when_we_low", q_b, 4'b0001);

        // Same-address collision at addr 2.
        drive(1'b1, 3'd2, 4'b0010, 1'b1, 3'd2);
        tick();
`ifdef DRAM_WR_BYPASS_EN
        exp_v = 4'b0010;
`else
        exp_v = 4'b0000;
`endif
        check("collision_edge", q_b, exp_v);
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd2);
        tick();
        check("collision_next_read", q_b, 4'b0010);

        // Concurrent different addresses: write 7 while reading 0.
        drive(1'b1, 3'd7, 4'b1010, 1'b1, 3'd0);
        tick();
        check("concurrent_read_addr0", q_b, 4'b0001);
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd7);
        tick();
        check("concurrent_read_addr7", q_b, 4'b1010);

        // Mid-run reset: write 1111 to addr 5, confirm, then reset off-edge.
        drive(1'b1, 3'd5, 4'b1111, 1'b0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd5);
        tick();
        check("pre_reset_addr5", q_b, 4'b1111);
        drive(1'b1, 3'd6, 4'b0101, 1'b0, 3'd5);
        #2 reset_L = 1'b0;
        #1 check("mid_reset_immediate", q_b, 4'b0000);
        tick();
        check("mid_reset_held", q_b, 4'b0000);
        drive(1'b0, 3'd0, 4'b0000, 1'b0, 3'd0);
        #2 reset_L = 1'b1;
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd5);
        tick();
        check("post_reset_addr5", q_b, 4'b0000);
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd7);
        tick();
        check("post_reset_addr7", q_b, 4'b0000);
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd6);
        tick();
        check("post_reset_inflight_addr6", q_b, 4'b0000);

        // Full sweep: mem[i] = i + 8, then read back in order.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(i), DW'(i + 8), 1'b0, 3'd0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 4'b0000, 1'b1, AW'(i));
            tick();
            check($sformatf("sweep_addr%0d", i), q_b, DW'(i + 8));
        end

        // Back-to-back reads: value appears only after the sampling edge.
        drive(1'b0, 3'd0, 4'b0000, 1'b1, 3'd2);
        #3 check("latency_before_edge", q_b, 4'b1111);
        tick();
        check("latency_after_edge", q_b, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_dram.md
Name: dual_port_dram

Overview:
Simple dual-port RAM used as the storage array of the FIFO blocks in the TLP path. It has one write-only port (A) and one read-only port (B), both synchronous to a single clock. Read data is registered, and the whole array clears on an asynchronous active-low reset.

Parameters:
DATA_WIDTH, 4, width of each stored word and of data_a/q_b.
ADDR_WIDTH, 3, width of addr_a/addr_b.
DEPTH, 8, number of words; must equal 2**ADDR_WIDTH.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset_L  input  1  asynchronous active-low reset.
data_a  input  DATA_WIDTH  write data, port A.
addr_a  input  ADDR_WIDTH  write address, port A.
we_a  input  1  write enable, port A, active-high.
addr_b  input  ADDR_WIDTH  read address, port B.
re_b  input  1  read enable, port B, active-high.
q_b  output  DATA_WIDTH  registered read data, port B.

Behaviour:
- Interface: one clock (clk); reset_L is asynchronous and active-low.
- Reset: while reset_L=0, every memory word = 0 and q_b = 0, independent of clk.
- Reset: writes and reads are ignored while reset_L is low.
- Reset: first update after release happens on the first rising clk edge with reset_L=1.
- Reset asserted mid-operation: immediately clears the array and q_b; any in-flight write is lost.
- Write: on rising clk with we_a=1, mem[addr_a] <= data_a. With we_a=0 the array is unchanged.
- Read: on rising clk with re_b=1, q_b <= mem[addr_b].
  - Latency: 1 cycle, so data is visible after the same edge that samples addr_b.
  - With re_b=0, q_b holds its last value.
- Ports are independent: a write and a read can occur on the same edge at different addresses with no interaction.
- Collision (we_a=1, re_b=1, addr_a==addr_b on the same edge), default: read-first. q_b gets the old contents; the new word is readable on the next read.
- Full address range 0..DEPTH-1 is valid; no wrap or bounds logic is needed beyond ADDR_WIDTH truncation.
- Contents are retained indefinitely while reset_L=1.
- No X propagation from reset-initialised storage.

Optional Feature:
Macro DRAM_WR_BYPASS_EN.
- Defined: a same-address collision forwards data_a directly to q_b on that edge (write-first). The memory is still written.
- Undefined: read-first behaviour as in Behaviour.
- Non-colliding accesses are identical in both builds.

Test Plan:
1. Reset: drive reset_L=0 mid-run after writing 4'b1111 to addr 5 -> q_b=0 immediately; after release, read addr 5 -> q_b=4'b0000.
2. Basic write/read: we_a=1, addr_a=0, data_a=4'b0001 for one edge, then re_b=1, addr_b=0 -> q_b=4'b0001 one edge later.
3. Read hold: after step 2, drop re_b and change addr_b to 3 -> q_b stays 4'b0001.
4. Collision: addr_a=addr_b=2, data_a=4'b0010, we_a=re_b=1.
   - Without macro: q_b=4'b0000 on that edge, then 4'b0010 on the next edge.
   - With DRAM_WR_BYPASS_EN: q_b=4'b0010 on that edge.
5. Concurrent different addresses: write 4'b1010 to addr 7 while reading addr 0 (holding 4'b0001) -> q_b=4'b0001; next read of addr 7 -> 4'b1010.
6. Full sweep: write value i+8 (mod 16) to every addr i in 0..7, then read all 8 back in order -> each matches, one-cycle latency, no aliasing.
